pipe_rx_lane_packer: RTL and testbench
======================================

Name: pipe_rx_lane_packer

Overview:
Multi-lane PIPE receive data packer. It sits between the per-lane PIPE Rx interface and the lane-deskew/descrambler stage. Per lane, it gathers PIPE beats of the generation-dependent width (8/16/32 bits) into fixed 32-bit words, carries block sync headers and the K flags with each word, and discards partial words on errors, misalignment, electrical idle or a GEN change.

Parameters:
LANES, 1, number of independent lanes (1..16)
GEN1_PIPEWIDTH, 8, PIPE width at Gen1; legal values 8/16/32
GEN2_PIPEWIDTH, 16, PIPE width at Gen2; legal values 8/16/32
GEN3_PIPEWIDTH, 32, PIPE width at Gen3; legal values 8/16/32
GEN4_PIPEWIDTH, 8, PIPE width at Gen4; legal values 8/16/32
GEN5_PIPEWIDTH, 8, PIPE width at Gen5; legal values 8/16/32

Ports:
clk  input  1  sole clock
reset  input  1  synchronous, active-high reset
GEN  input  3  current generation, 1..5; any other value means no link
RxValid  input  LANES  per-lane beat valid
RxStartBlock  input  LANES  first beat of a 128b/130b block
RxStatus  input  3*LANES  per-lane status; nonzero means error
RxSyncHeader  input  2*LANES  block sync header, qualified by RxStartBlock
RxElectricalIdle  input  LANES  per-lane electrical idle
RxData  input  32*LANES  per-lane data; low width bits used
RxDataK  input  4*LANES  per-lane K flags; low width/8 bits used
PIPEData  output  32*LANES  packed word; earliest byte in [7:0]
PIPEDataK  output  4*LANES  K flag per packed byte
PIPEDataValid  output  LANES  one-cycle pulse per packed word
PIPEBlockStart  output  LANES  word is the first of a block
PIPESyncHeader  output  2*LANES  header latched at the last block start
PIPEError  output  LANES  one-cycle pulse when a partial word is discarded due to an error
PIPEElectricalIdle  output  LANES  registered RxElectricalIdle
PIPEWIDTH  output  6  width for the registered GEN (0 if GEN is invalid)

Behaviour:
- Reset: all outputs 0, all accumulators empty (cnt=0), gen_q=0, lane state EIDLE.
- gen_q registers GEN each cycle. Per-beat byte count B = width(gen_q)/8. PIPEWIDTH = width(gen_q), registered.
- Per-lane FSM, EIDLE/ACTIVE:
  - EIDLE→ACTIVE when RxElectricalIdle=0.
  - ACTIVE→EIDLE when RxElectricalIdle=1. On this transition, flush the partial word with no error pulse.
- Accepted beat: lane is ACTIVE, RxValid=1, RxStatus=0, GEN==gen_q, and GEN is valid.
  - Bytes go to acc[cnt*8 +: B*8]; K flags go to kacc[cnt +: B].
  - cnt += B (2-bit counter wraps at 4).
- Word complete: cnt+B==4 on an accepted beat.
  - On the next cycle: PIPEData = completed word, PIPEDataK = completed K flags, PIPEDataValid=1 for one cycle. Latency is 1 clk from the completing beat.
  - With B=4, every accepted beat emits a word.
- Gen3+ (gen_q>=3): PIPEDataK is forced to 0.
- RxValid=0: partial word is held; no output.
- RxValid=1 with RxStatus!=0: discard partial word (cnt=0), PIPEError pulse next cycle, beat dropped.
- RxStartBlock on an accepted beat:
  - cnt==0: latch RxSyncHeader; the word containing this beat has PIPEBlockStart=1.
  - cnt!=0: misaligned. Discard partial, PIPEError pulse, then treat the beat as the first beat of a new word (cnt restarts from 0, header latched).
- PIPESyncHeader holds its value until the next block start or reset.
- GEN!=gen_q: discard all lanes' partial words, no error, beat dropped.
- Invalid GEN: nothing is accepted, PIPEWIDTH=0.
- PIPEDataValid=0 ⇒ PIPEData/PIPEDataK hold their last values.
- Lanes are fully independent; only gen_q is shared.
- Reset mid-word clears the partial word; nothing is emitted for it.

Test Plan:
- Gen1, lane0 active, four beats 0x11(K),0x22,0x33,0x44 → one cycle after the 4th beat: PIPEData=0x44332211, PIPEDataK=4'b0001, PIPEDataValid=1 for 1 cycle, PIPEWIDTH=8.
- Gen2, beats 0xBBAA, RxValid=0 for 3 cycles, then 0xDDCC → PIPEData=0xDDCCBBAA one cycle after the second beat; no output during the gap.
- Gen3, RxStartBlock=1, RxSyncHeader=2'b01, RxData=0x1E2D3C4B, DataK=4'hF → next cycle PIPEData=0x1E2D3C4B, PIPEDataK=0, PIPEBlockStart=1, PIPESyncHeader=01.
- Gen1, bytes 0xAA,0xBB, then RxValid=1 with RxStatus=3'b100 → PIPEError pulse, no word. Next bytes 0x01..0x04 → PIPEData=0x04030201.
- Gen4 (8-bit), RxStartBlock on the 2nd byte of a word → PIPEError pulse. That byte plus the next 3 form a word with PIPEBlockStart=1.
- LANES=2, Gen1: lane0 bytes 1..4, lane1 bytes 1..3, then lane1 RxElectricalIdle=1 → lane0 word 0x04030201 emitted; lane1 emits nothing and PIPEElectricalIdle[1]=1. Reset after 3 lane0 bytes → the next 4 bytes form a clean word.

Source files
------------

// File: rtl/pipe_rx_lane_packer.sv
// rtl/pipe_rx_lane_packer.sv - per-lane PIPE Rx beat packer into 32-bit words
module pipe_rx_lane_packer #(
    parameter int LANES          = 1,
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 16,
    parameter int GEN3_PIPEWIDTH = 32,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            GEN,
    input  logic [LANES-1:0]      RxValid,
    input  logic [LANES-1:0]      RxStartBlock,
    input  logic [3*LANES-1:0]    RxStatus,
    input  logic [2*LANES-1:0]    RxSyncHeader,
    input  logic [LANES-1:0]      RxElectricalIdle,
    input  logic [32*LANES-1:0]   RxData,
    input  logic [4*LANES-1:0]    RxDataK,
    output logic [32*LANES-1:0]   PIPEData,
    output logic [4*LANES-1:0]    PIPEDataK,
    output logic [LANES-1:0]      PIPEDataValid,
    output logic [LANES-1:0]      PIPEBlockStart,
    output logic [2*LANES-1:0]    PIPESyncHeader,
    output logic [LANES-1:0]      PIPEError,
    output logic [LANES-1:0]      PIPEElectricalIdle,
    output logic [5:0]            PIPEWIDTH
);

    typedef enum logic {S_EIDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    function automatic logic [5:0] gen_width(input logic [2:0] g);
        case (g)
            3'd1:    return 6'(GEN1_PIPEWIDTH);
            3'd2:    return 6'(GEN2_PIPEWIDTH);
            3'd3:    return 6'(GEN3_PIPEWIDTH);
            3'd4:    return 6'(GEN4_PIPEWIDTH);
            3'd5:    return 6'(GEN5_PIPEWIDTH);
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [2:0] gen_bytes(input logic [2:0] g);
        case (g)
            3'd1:    return 3'(GEN1_PIPEWIDTH / 8);
            3'd2:    return 3'(GEN2_PIPEWIDTH / 8);
            3'd3:    return 3'(GEN3_PIPEWIDTH / 8);
            3'd4:    return 3'(GEN4_PIPEWIDTH / 8);
            3'd5:    return 3'(GEN5_PIPEWIDTH / 8);
            default: return 3'd0;
        endcase
    endfunction

    logic [2:0] gen_q;
    logic [2:0] nbytes;
    logic       gen_chg;
    logic       gen_ok;
    logic       k_kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            gen_q <= 3'd0;
        end else begin
            gen_q <= GEN;
        end
    end

    assign nbytes    = gen_bytes(gen_q);
    assign gen_chg   = (GEN != gen_q);
    assign gen_ok    = !gen_chg && (nbytes != 3'd0);
    // 128b/130b generations carry no K symbols
    assign k_kill    = (gen_q >= 3'd3);
    assign PIPEWIDTH = gen_width(gen_q);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] lane_data;
        logic [3:0]  lane_k;
        logic [2:0]  lane_status;
        logic        lane_eidle;
        logic        lane_start;

        state_t      state_q, state_d;
        logic [1:0]  cnt_q, cnt_d;
        logic [31:0] acc_q, acc_d;
        logic [3:0]  kacc_q, kacc_d;
        logic        bs_pend_q, bs_pend_d;
        logic [31:0] data_q, data_d;
        logic [3:0]  datak_q, datak_d;
        logic        valid_q, valid_d;
        logic        bstart_q, bstart_d;
        logic [1:0]  sync_q, sync_d;
        logic        err_q, err_d;
        logic        eidle_q;

        logic        leaving, live, accept, beat_err, misalign, complete;
        logic [1:0]  base;
        logic [2:0]  sum;
        logic [1:0]  src;

        assign lane_data   = RxData[l*32 +: 32];
        assign lane_k      = RxDataK[l*4 +: 4];
        assign lane_status = RxStatus[l*3 +: 3];
        assign lane_eidle  = RxElectricalIdle[l];
        assign lane_start  = RxStartBlock[l];

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= S_EIDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                S_EIDLE:  if (!lane_eidle) state_d = S_ACTIVE;
                S_ACTIVE: if (lane_eidle)  state_d = S_EIDLE;
                default:  state_d = S_EIDLE;
            endcase
        end

        assign leaving  = (state_q == S_ACTIVE) && lane_eidle;
        assign live     = (state_q == S_ACTIVE) && !lane_eidle;
        assign accept   = live && RxValid[l] && (lane_status == 3'd0) && gen_ok;
        assign beat_err = live && RxValid[l] && (lane_status != 3'd0) && !gen_chg;
        assign misalign = accept && lane_start && (cnt_q != 2'd0);
        // a block start always begins a fresh word, misaligned or not
        assign base     = (accept && lane_start) ? 2'd0 : cnt_q;
        assign sum      = {1'b0, base} + nbytes;
        assign complete = accept && (sum == 3'd4);

        always_comb begin
            acc_d     = acc_q;
            kacc_d    = kacc_q;
            cnt_d     = cnt_q;
            bs_pend_d = bs_pend_q;
            sync_d    = sync_q;
            src       = 2'd0;
            for (int b = 0; b < 4; b++) begin
                src = 2'(b) - base;
                if (accept && (3'(b) >= {1'b0, base}) && (3'(b) < sum)) begin
                    acc_d[b*8 +: 8] = lane_data[{src, 3'b000} +: 8];
                    kacc_d[b]       = lane_k[src];
                end
            end
            if (leaving || gen_chg || beat_err) begin
                cnt_d     = 2'd0;
                bs_pend_d = 1'b0;
            end else if (accept) begin
                cnt_d     = sum[1:0];
                bs_pend_d = complete ? 1'b0 : (lane_start || bs_pend_q);
                if (lane_start) sync_d = RxSyncHeader[l*2 +: 2];
            end
        end

        always_comb begin
            valid_d  = complete;
            err_d    = beat_err || misalign;
            data_d   = complete ? acc_d : data_q;
            datak_d  = complete ? (k_kill ? 4'd0 : kacc_d) : datak_q;
            bstart_d = complete ? (bs_pend_q || lane_start) : bstart_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q     <= 2'd0;
                acc_q     <= 32'd0;
                kacc_q    <= 4'd0;
                bs_pend_q <= 1'b0;
                data_q    <= 32'd0;
                datak_q   <= 4'd0;
                valid_q   <= 1'b0;
                bstart_q  <= 1'b0;
                sync_q    <= 2'd0;
                err_q     <= 1'b0;
                eidle_q   <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                acc_q     <= acc_d;
                kacc_q    <= kacc_d;
                bs_pend_q <= bs_pend_d;
                data_q    <= data_d;
                datak_q   <= datak_d;
                valid_q   <= valid_d;
                bstart_q  <= bstart_d;
                sync_q    <= sync_d;
                err_q     <= err_d;
                eidle_q   <= lane_eidle;
            end
        end

        assign PIPEData[l*32 +: 32]     = data_q;
        assign PIPEDataK[l*4 +: 4]      = datak_q;
        assign PIPEDataValid[l]         = valid_q;
        assign PIPEBlockStart[l]        = bstart_q;
        assign PIPESyncHeader[l*2 +: 2] = sync_q;
        assign PIPEError[l]             = err_q;
        assign PIPEElectricalIdle[l]    = eidle_q;
    end

endmodule

// File: tb/tb_pipe_rx_lane_packer.sv
// tb/tb_pipe_rx_lane_packer.sv - scoreboard bench for pipe_rx_lane_packer
module tb_pipe_rx_lane_packer;
    localparam int LANES = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           GEN;
    logic [LANES-1:0]     RxValid, RxStartBlock, RxElectricalIdle;
    logic [3*LANES-1:0]   RxStatus;
    logic [2*LANES-1:0]   RxSyncHeader;
    logic [32*LANES-1:0]  RxData;
    logic [4*LANES-1:0]   RxDataK;
    logic [32*LANES-1:0]  PIPEData;
    logic [4*LANES-1:0]   PIPEDataK;
    logic [LANES-1:0]     PIPEDataValid, PIPEBlockStart, PIPEError, PIPEElectricalIdle;
    logic [2*LANES-1:0]   PIPESyncHeader;
    logic [5:0]           PIPEWIDTH;

    pipe_rx_lane_packer #(.LANES(LANES)) dut (
        .clk(clk), .reset(reset), .GEN(GEN),
        .RxValid(RxValid), .RxStartBlock(RxStartBlock), .RxStatus(RxStatus),
        .RxSyncHeader(RxSyncHeader), .RxElectricalIdle(RxElectricalIdle),
        .RxData(RxData), .RxDataK(RxDataK),
        .PIPEData(PIPEData), .PIPEDataK(PIPEDataK), .PIPEDataValid(PIPEDataValid),
        .PIPEBlockStart(PIPEBlockStart), .PIPESyncHeader(PIPESyncHeader),
        .PIPEError(PIPEError), .PIPEElectricalIdle(PIPEElectricalIdle),
        .PIPEWIDTH(PIPEWIDTH)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        bs;
        logic [1:0]  sh;
        int          cyc;
    } exp_t;

    exp_t        sb[LANES][$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          err_seen[LANES];
    int          exp_err[LANES];
    logic [1:0]  exp_sh[LANES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int l = 0; l < LANES; l++) begin
                if (PIPEError[l]) err_seen[l]++;
                if (PIPEDataValid[l]) begin
                    if (sb[l].size() == 0) begin
                        check($sformatf("unexpected_word_l%0d", l), 64'(PIPEData[l*32 +: 32]), 64'hDEAD_0000_0000);
                    end else begin
                        exp_t e;
                        e = sb[l].pop_front();
                        check($sformatf("data_l%0d", l), 64'(PIPEData[l*32 +: 32]), 64'(e.d));
                        check($sformatf("datak_l%0d", l), 64'(PIPEDataK[l*4 +: 4]), 64'(e.k));
                        check($sformatf("bstart_l%0d", l), 64'(PIPEBlockStart[l]), 64'(e.bs));
                        check($sformatf("synchdr_l%0d", l), 64'(PIPESyncHeader[l*2 +: 2]), 64'(e.sh));
                        check($sformatf("latency_l%0d", l), 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drives one beat; when `last` is set the word it completes is expected next cycle
    task automatic beat(input int l, input logic [31:0] d, input logic [3:0] k,
                        input logic sb_i, input logic [1:0] sh, input logic [2:0] st,
                        input logic last, input logic [31:0] wd, input logic [3:0] wk,
                        input logic wbs);
        exp_t e;
        RxValid[l]          = 1'b1;
        RxData[l*32 +: 32]  = d;
        RxDataK[l*4 +: 4]   = k;
        RxStartBlock[l]     = sb_i;
        RxSyncHeader[l*2 +: 2] = sh;
        RxStatus[l*3 +: 3]  = st;
        if (sb_i && st == 3'd0) exp_sh[l] = sh;
        if (last) begin
            e.d = wd; e.k = wk; e.bs = wbs; e.sh = exp_sh[l]; e.cyc = cyc + 1;
            sb[l].push_back(e);
        end
        @(posedge clk);
        #1;
        RxValid[l]         = 1'b0;
        RxStartBlock[l]    = 1'b0;
        RxStatus[l*3 +: 3] = 3'd0;
    endtask

    task automatic set_gen(input logic [2:0] g);
        GEN = g;
        idle(2);
    endtask

    initial begin
        reset = 1'b1; GEN = 3'd0;
        RxValid = '0; RxStartBlock = '0; RxStatus = '0; RxSyncHeader = '0;
        RxElectricalIdle = '1; RxData = '0; RxDataK = '0;
        for (int l = 0; l < LANES; l++) begin
            err_seen[l] = 0; exp_err[l] = 0; exp_sh[l] = 2'b00;
        end
        idle(3);
        check("rst_valid", 64'(PIPEDataValid), 64'd0);
        check("rst_data", 64'(PIPEData), 64'd0);
        check("rst_width", 64'(PIPEWIDTH), 64'd0);
        check("rst_err", 64'(PIPEError), 64'd0);
        check("rst_eidle", 64'(PIPEElectricalIdle), 64'd0);
        reset = 1'b0;
        RxElectricalIdle = '0;
        set_gen(3'd1);
        check("width_gen1", 64'(PIPEWIDTH), 64'd8);

        beat(0, 32'h11, 4'h1, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h22, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h33, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h44, 4'h0, 0, 2'b00, 3'd0, 1, 32'h44332211, 4'b0001, 0);
        idle(2);

        set_gen(3'd2);
        check("width_gen2", 64'(PIPEWIDTH), 64'd16);
        beat(0, 32'hBBAA, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        idle(3);
        beat(0, 32'hDDCC, 4'h0, 0, 2'b00, 3'd0, 1, 32'hDDCCBBAA, 4'h0, 0);
        idle(2);

        set_gen(3'd3);
        check("width_gen3", 64'(PIPEWIDTH), 64'd32);
        beat(0, 32'h1E2D3C4B, 4'hF, 1, 2'b01, 3'd0, 1, 32'h1E2D3C4B, 4'h0, 1);
        idle(2);

        set_gen(3'd1);
        beat(0, 32'hAA, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'hBB, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        exp_err[0]++;
        beat(0, 32'hCC, 4'h0, 0, 2'b00, 3'b100, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            beat(0, 32'(i), 4'h0, 0, 2'b00, 3'd0, i == 4, 32'h04030201, 4'h0, 0);
        idle(2);
        check("err_after_status", 64'(err_seen[0]), 64'(exp_err[0]));

        set_gen(3'd4);
        beat(0, 32'h10, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        exp_err[0]++;
        beat(0, 32'h20, 4'h0, 1, 2'b10, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h30, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h40, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h50, 4'h0, 0, 2'b00, 3'd0, 1, 32'h50403020, 4'h0, 1);
        idle(2);
        check("err_after_misalign", 64'(err_seen[0]), 64'(exp_err[0]));

        set_gen(3'd6);
        check("width_invalid", 64'(PIPEWIDTH), 64'd0);
        beat(0, 32'h77, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h77, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h77, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        beat(0, 32'h77, 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        idle(2);

        set_gen(3'd1);
        for (int i = 1; i <= 3; i++) begin
            beat(0, 32'(i), 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
            beat(1, 32'(i), 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        end
        beat(0, 32'h04, 4'h0, 0, 2'b00, 3'd0, 1, 32'h04030201, 4'h0, 0);
        RxElectricalIdle[1] = 1'b1;
        idle(2);
        check("eidle_lane1", 64'(PIPEElectricalIdle), 64'b10);
        RxElectricalIdle[1] = 1'b0;
        idle(2);
        for (int i = 5; i <= 8; i++)
            beat(1, 32'(i), 4'h0, 0, 2'b00, 3'd0, i == 8, 32'h08070605, 4'h0, 0);
        idle(2);

        for (int i = 1; i <= 3; i++)
            beat(0, 32'(8'hE0 + i), 4'h0, 0, 2'b00, 3'd0, 0, 0, 0, 0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        for (int l = 0; l < LANES; l++) exp_sh[l] = 2'b00;
        idle(3);
        for (int i = 1; i <= 4; i++)
            beat(0, 32'(8'hA0 + i), 4'h0, 0, 2'b00, 3'd0, i == 4, 32'hA4A3A2A1, 4'h0, 0);
        idle(3);

        for (int l = 0; l < LANES; l++) begin
            check($sformatf("sb_empty_l%0d", l), 64'(sb[l].size()), 64'd0);
            check($sformatf("err_total_l%0d", l), 64'(err_seen[l]), 64'(exp_err[l]));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
